multi_edge_pulse_gen: RTL and testbench

//  Multi-channel successor to the single-bit level-to-pulse converter.
//  - Per channel: optional input synchroniser, edge detection selectable as rise/fall/both/off, and a pulse stretched to PULSE_W cycles.
//  - Turns level/handshake signals crossing into the CLK domain into one-shot strobes.
//  - Typical use: between the CDC synchronisers and the control FSMs.

---
 rtl/pulse_gen_pkg.sv | 15 +
 rtl/pulse_gen_ch.sv | 83 ++++++++
 rtl/multi_edge_pulse_gen.sv | 56 +++++
 tb/tb_multi_edge_pulse_gen.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_gen_pkg.sv
// Shared constants and helpers for the multi-channel edge-to-pulse generator.
// Edge mode encodings match the per-channel EDGE_MODE field layout.
package pulse_gen_pkg;

  localparam logic [1:0] EDGE_OFF  = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  // Width of a down-counter that must hold the value pulse_w.
  function automatic int cnt_width(input int pulse_w);
    return (pulse_w < 1) ? 1 : $clog2(pulse_w + 1);
  endfunction

endpackage

// File: rtl/pulse_gen_ch.sv
// One channel: optional synchroniser, edge detect, pulse stretcher; PULSE_SIG rises SYNC_STAGES+1 edges after sampling.
// Optional saturating edge counter when PULSE_GEN_EDGE_COUNT_EN is defined.
module pulse_gen_ch
  import pulse_gen_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_W     = 1
`ifdef PULSE_GEN_EDGE_COUNT_EN
  ,
  parameter int CNT_W       = 8
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             lvl,
  input  logic [1:0]       mode,
`ifdef PULSE_GEN_EDGE_COUNT_EN
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] edge_cnt,
`endif
  output logic             pulse
);

  localparam int CW = cnt_width(PULSE_W);

  logic          sync;
  logic          prev;
  logic          hit;
  logic          rise_en;
  logic          fall_en;
  logic [CW-1:0] cnt;

  generate
    if (SYNC_STAGES == 0) begin : g_no_sync
      assign sync = lvl;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sff;
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          sff <= '0;
        end else begin
          sff <= (sff << 1) | SYNC_STAGES'(lvl);
        end
      end
      assign sync = sff[SYNC_STAGES-1];
    end
  endgenerate

  assign rise_en = (mode == EDGE_RISE) || (mode == EDGE_BOTH);
  assign fall_en = (mode == EDGE_FALL) || (mode == EDGE_BOTH);
  assign hit     = (mode != EDGE_OFF) &&
                   ((rise_en && sync && !prev) || (fall_en && !sync && prev));

  // PREV tracks even in mode off, so re-enabling never fires on a stale edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      prev  <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      prev <= sync;
      if (hit) begin
        cnt <= CW'(PULSE_W);
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      pulse <= (cnt != '0);
    end
  end

`ifdef PULSE_GEN_EDGE_COUNT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
    end else if (cnt_clr) begin
      edge_cnt <= '0;
    end else if (hit && (edge_cnt != '1)) begin
      edge_cnt <= edge_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: rtl/multi_edge_pulse_gen.sv
// NUM_CH independent edge-to-pulse channels; BUSY mirrors PULSE_SIG for status registers.
// Define PULSE_GEN_EDGE_COUNT_EN to add per-channel saturating edge counters with CNT_CLR/EDGE_CNT.
module multi_edge_pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_W     = 1,
  parameter int CNT_W       = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NUM_CH-1:0]       LVL_SIG,
  input  logic [2*NUM_CH-1:0]     EDGE_MODE,
`ifdef PULSE_GEN_EDGE_COUNT_EN
  input  logic                    CNT_CLR,
  output logic [CNT_W*NUM_CH-1:0] EDGE_CNT,
`endif
  output logic [NUM_CH-1:0]       PULSE_SIG,
  output logic [NUM_CH-1:0]       BUSY
);

  generate
    if (NUM_CH < 1 || PULSE_W < 1 || SYNC_STAGES < 0 || SYNC_STAGES == 1 || CNT_W < 1)
    begin : g_bad_cfg
      $error("multi_edge_pulse_gen: unsupported parameter combination");
    end
  endgenerate

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_ch
      pulse_gen_ch #(
        .SYNC_STAGES (SYNC_STAGES),
        .PULSE_W     (PULSE_W)
`ifdef PULSE_GEN_EDGE_COUNT_EN
        ,
        .CNT_W       (CNT_W)
`endif
      ) u_ch (
        .CLK      (CLK),
        .RST      (RST),
        .lvl      (LVL_SIG[i]),
        .mode     (EDGE_MODE[2*i +: 2]),
`ifdef PULSE_GEN_EDGE_COUNT_EN
        .cnt_clr  (CNT_CLR),
        .edge_cnt (EDGE_CNT[CNT_W*i +: CNT_W]),
`endif
        .pulse    (PULSE_SIG[i])
      );
    end
  endgenerate

  assign BUSY = PULSE_SIG;

endmodule

// File: tb/tb_multi_edge_pulse_gen.sv
// Bench for multi_edge_pulse_gen: three configurations share stimulus and are
// checked every edge against a history-based model of the edge/pulse rules.
module tb_multi_edge_pulse_gen;

  localparam int HN = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] lvl = '0;
  logic [7:0] mode = '0;
  logic       clr = 1'b0;

  logic [3:0] pa, pb, pc, ba, bb, bc;
`ifdef PULSE_GEN_EDGE_COUNT_EN
  logic [7:0] ca, cb, cc;
`endif

  always #5 clk = ~clk;

  multi_edge_pulse_gen #(.NUM_CH(4), .SYNC_STAGES(0), .PULSE_W(1), .CNT_W(2)) ua (
    .CLK(clk), .RST(rst), .LVL_SIG(lvl), .EDGE_MODE(mode),
`ifdef PULSE_GEN_EDGE_COUNT_EN
    .CNT_CLR(clr), .EDGE_CNT(ca),
`endif
    .PULSE_SIG(pa), .BUSY(ba));

  multi_edge_pulse_gen #(.NUM_CH(4), .SYNC_STAGES(2), .PULSE_W(3), .CNT_W(2)) ub (
    .CLK(clk), .RST(rst), .LVL_SIG(lvl), .EDGE_MODE(mode),
`ifdef PULSE_GEN_EDGE_COUNT_EN
    .CNT_CLR(clr), .EDGE_CNT(cb),
`endif
    .PULSE_SIG(pb), .BUSY(bb));

  multi_edge_pulse_gen #(.NUM_CH(4), .SYNC_STAGES(0), .PULSE_W(4), .CNT_W(2)) uc (
    .CLK(clk), .RST(rst), .LVL_SIG(lvl), .EDGE_MODE(mode),
`ifdef PULSE_GEN_EDGE_COUNT_EN
    .CNT_CLR(clr), .EDGE_CNT(cc),
`endif
    .PULSE_SIG(pc), .BUSY(bc));

  // Inputs seen at each edge since the last reset release; edge 0 is the first.
  logic [3:0] lvl_h [HN];
  logic [7:0] mode_h[HN];
  logic       clr_h [HN];
  int         n = 0;
  int         errs = 0;
  int         checks = 0;
  int         ecm [3][4];
  int         hi  [3];
  int         rises[3];
  logic       last0[3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s edge=%0d got=%0h want=%0h", tag, n, got, want);
    end
  endtask

  // Synchroniser output at edge m is the input sampled S edges earlier; zero before reset release.
  function automatic bit lvl_at(int m, int ch);
    return (m >= 0) ? lvl_h[m][ch] : 1'b0;
  endfunction

  function automatic bit hit_at(int m, int ch, int s);
    bit cur, prv;
    logic [1:0] md;
    cur = lvl_at(m - s, ch);
    prv = lvl_at(m - s - 1, ch);
    md  = mode_h[m][2*ch +: 2];
    return (md[0] && cur && !prv) || (md[1] && !cur && prv);
  endfunction

  // Output after edge e is high iff some hit landed in the W edges before it.
  function automatic bit exp_pulse(int e, int ch, int s, int w);
    for (int m = e - w; m < e; m++)
      if (m >= 0 && hit_at(m, ch, s)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int s_of(int k);
    return (k == 1) ? 2 : 0;
  endfunction

  function automatic int w_of(int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  task automatic clear_tallies();
    for (int k = 0; k < 3; k++) begin
      hi[k] = 0;
      rises[k] = 0;
    end
  endtask

  task automatic model_reset();
    n = 0;
    for (int k = 0; k < 3; k++) begin
      last0[k] = 1'b0;
      for (int c = 0; c < 4; c++) ecm[k][c] = 0;
    end
  endtask

  // Called just after a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    logic [3:0] exp_p [3];
    logic [3:0] got_p [3];
    logic [3:0] got_b [3];
    lvl_h[n]  = lvl;
    mode_h[n] = mode;
    clr_h[n]  = clr;
    @(posedge clk);
    #1;
    got_p[0] = pa; got_p[1] = pb; got_p[2] = pc;
    got_b[0] = ba; got_b[1] = bb; got_b[2] = bc;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 4; c++) exp_p[k][c] = exp_pulse(n, c, s_of(k), w_of(k));
      chk($sformatf("pulse_%0d", k), 32'(got_p[k]), 32'(exp_p[k]));
      chk($sformatf("busy_%0d", k), 32'(got_b[k]), 32'(exp_p[k]));
      if (got_p[k][0]) hi[k]++;
      if (got_p[k][0] && !last0[k]) rises[k]++;
      last0[k] = got_p[k][0];
    end
`ifdef PULSE_GEN_EDGE_COUNT_EN
    begin
      logic [7:0] exp_c [3];
      logic [7:0] got_c [3];
      got_c[0] = ca; got_c[1] = cb; got_c[2] = cc;
      for (int k = 0; k < 3; k++) begin
        for (int c = 0; c < 4; c++) begin
          if (clr_h[n]) ecm[k][c] = 0;
          else if (hit_at(n, c, s_of(k)) && ecm[k][c] < 3) ecm[k][c]++;
          exp_c[k][2*c +: 2] = 2'(ecm[k][c]);
        end
        chk($sformatf("ecnt_%0d", k), 32'(got_c[k]), 32'(exp_c[k]));
      end
    end
`endif
    n++;
    @(negedge clk);
  endtask

  task automatic steps(input int cnt);
    for (int i = 0; i < cnt; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog edge=%0d got=timeout want=finish", n);
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    clear_tallies();
    @(negedge clk);
    // Reset state while held in reset, with an input already high.
    lvl  = 4'b0001;
    mode = 8'h01;
    #1;
    chk("rst_pulse", 32'({pa, pb, pc}), 32'h0);
    chk("rst_busy", 32'({ba, bb, bc}), 32'h0);
`ifdef PULSE_GEN_EDGE_COUNT_EN
    chk("rst_ecnt", 32'({ca, cb, cc}), 32'h0);
`endif
    @(negedge clk);
    rst = 1'b1;
    steps(6);
    chk("rel_high_pulses", 32'(hi[0]), 32'd1);

    lvl = 4'b0000;
    steps(6);

    // Legacy-equivalent single pulse on a held rise.
    clear_tallies();
    lvl[0] = 1'b1;
    steps(10);
    chk("legacy_hi", 32'(hi[0]), 32'd1);
    chk("legacy_rises", 32'(rises[0]), 32'd1);

    // Fall-only with synchroniser: three-cycle pulse, rise ignored.
    mode[1:0] = 2'b10;
    steps(6);
    clear_tallies();
    lvl[0] = 1'b0;
    steps(8);
    lvl[0] = 1'b1;
    steps(8);
    chk("fall_hi", 32'(hi[1]), 32'd3);
    chk("fall_rises", 32'(rises[1]), 32'd1);

    // Both edges, retrigger every two cycles: one unbroken 8-cycle pulse.
    mode[1:0] = 2'b11;
    steps(6);
    clear_tallies();
    for (int i = 0; i < 3; i++) begin
      lvl[0] = ~lvl[0];
      steps(2);
    end
    steps(10);
    chk("retrig_hi", 32'(hi[2]), 32'd8);
    chk("retrig_rises", 32'(rises[2]), 32'd1);

    // Asynchronous reset in the middle of a pulse.
    lvl[0] = ~lvl[0];
    steps(2);
    chk("pre_arst_active", 32'(pc[0]), 32'd1);
    rst = 1'b0;
    #1;
    chk("arst_pulse", 32'({pa, pb, pc}), 32'h0);
    chk("arst_busy", 32'({ba, bb, bc}), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    // Randomised multi-channel traffic with occasional mode changes and clears.
    for (int i = 0; i < 400; i++) begin
      lvl = lvl ^ (4'($urandom) & 4'($urandom));
      if ($urandom_range(15) == 0) mode = 8'($urandom);
      clr = ($urandom_range(15) == 0);
      step();
    end
    clr = 1'b0;

`ifdef PULSE_GEN_EDGE_COUNT_EN
    // Saturation after five hits, then a clear that coincides with a hit.
    mode = 8'hFF;
    clr  = 1'b1;
    steps(4);
    clr  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      lvl[0] = ~lvl[0];
      steps(2);
    end
    chk("ecnt_sat", 32'(ca[1:0]), 32'd3);
    lvl[0] = ~lvl[0];
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("ecnt_clr_hit", 32'(ca[1:0]), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
